// File: rtl/vga_lanes.sv
// vga_lanes: LANES-wide pixel FIFO bank feeding a programmable VGA raster generator.
// Optional interlaced scan (input interlaced, output field) is built when VGA_LANES_INTERLACE_EN is defined.
module vga_lanes #(
    parameter int                 LANES = 3,
    parameter int                 DEPTH = 512,
    parameter int                 PIX_W = 8,
    parameter logic [3*PIX_W-1:0] FILL  = {{PIX_W{1'b1}}, {PIX_W{1'b0}}, {PIX_W{1'b0}}},
    parameter int                 BURST = 342
) (
    input  logic                         clk_sys,
    input  logic                         vga_reset_n,
    input  logic                         ce_pix,
    input  logic [15:0]                  H,
    input  logic [15:0]                  V,
    input  logic [7:0]                   HFP,
    input  logic [7:0]                   HS,
    input  logic [7:0]                   HBP,
    input  logic [7:0]                   VFP,
    input  logic [7:0]                   VS,
    input  logic [7:0]                   VBP,
    input  logic [$clog2(LANES+1)-1:0]   wr_cnt,
    input  logic [LANES*3*PIX_W-1:0]     wr_data,
`ifdef VGA_LANES_INTERLACE_EN
    input  logic                         interlaced,
    output logic                         field,
`endif
    output logic                         ready,
    output logic [23:0]                  queue,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         hblank,
    output logic                         vblank,
    output logic                         de,
    output logic [3*PIX_W-1:0]           rgb,
    output logic [31:0]                  frame,
    output logic [15:0]                  vcount,
    output logic                         underflow
);

    localparam int          PW     = 3 * PIX_W;
    localparam int          AW     = $clog2(DEPTH);
    localparam int          LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [23:0] CAP_Q  = 24'(LANES * DEPTH);
    localparam logic [23:0] BURST_Q = 24'(BURST);

    // Lane index arithmetic modulo LANES; both operands stay below 2*LANES
    function automatic logic [LW-1:0] lane_add(input logic [LW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        return LW'((s >= LANES) ? s - LANES : s);
    endfunction

    logic [15:0]   h_cnt_r, v_cnt_r, h_next_s, v_next_s;
    logic          started_r, wrap_s;
    logic          hblank_r, vblank_r, de_r, hsync_r, vsync_r, underflow_r;
    logic [PW-1:0] rgb_r;
    logic [31:0]   frame_r;
    logic [LW-1:0] wr_ptr_r, rd_ptr_r;
    logic [16:0]   hs_start_s, hs_end_s, htot_s, vs_start_s, vs_end_s, vtot_s, vs_h_s;
    logic [1:0]    v_step_s;
    logic [15:0]   v_base_s;
    logic          hb_nx_s, vb_nx_s, hs_nx_s, vs_nx_s, vs_upd_s;

    logic          wr_en_s   [LANES];
    logic [PW-1:0] wr_pix_s  [LANES];
    logic          rd_en_s   [LANES];
    logic [AW:0]   lane_cnt_s [LANES];
    logic [PW-1:0] lane_head_s [LANES];
    logic [PW-1:0] rd_head_s;
    logic          rd_have_s, rd_go_s;
    logic [23:0]   queue_s;

    assign hs_start_s = {1'b0, H} + {9'd0, HFP};
    assign hs_end_s   = hs_start_s + {9'd0, HS};
    assign htot_s     = hs_end_s + {9'd0, HBP};
    assign vs_start_s = {1'b0, V} + {9'd0, VFP};
    assign vs_end_s   = vs_start_s + {9'd0, VS};
    assign vtot_s     = vs_end_s + {9'd0, VBP};

`ifdef VGA_LANES_INTERLACE_EN
    logic field_r, field_nx_s;
    assign field_nx_s = interlaced ? ~field_r : 1'b0;
    assign v_step_s   = interlaced ? 2'd2 : 2'd1;
    assign v_base_s   = {15'd0, field_nx_s};
    // Field 1 moves its vsync edges to the middle of the line
    assign vs_h_s     = field_r ? {1'b0, htot_s[16:1]} : hs_start_s;
    assign field      = field_r;

    // Field toggles at every vertical wrap while interlaced
    always_ff @(posedge clk_sys or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            field_r <= 1'b0;
        end else if (ce_pix && wrap_s) begin
            field_r <= field_nx_s;
        end
    end
`else
    assign v_step_s = 2'd1;
    assign v_base_s = 16'd0;
    assign vs_h_s   = hs_start_s;
`endif

    // Next raster position; the first ce_pix after reset only primes the outputs at (0,0)
    always_comb begin
        h_next_s = 16'd0;
        v_next_s = 16'd0;
        wrap_s   = 1'b0;
        if (started_r) begin
            h_next_s = (({1'b0, h_cnt_r} + 17'd1) >= htot_s) ? 16'd0 : h_cnt_r + 16'd1;
            if ({1'b0, h_cnt_r} == hs_start_s) begin
                if (({1'b0, v_cnt_r} + {15'd0, v_step_s}) >= vtot_s) begin
                    wrap_s   = 1'b1;
                    v_next_s = v_base_s;
                end else begin
                    v_next_s = v_cnt_r + {14'd0, v_step_s};
                end
            end else begin
                v_next_s = v_cnt_r;
            end
        end else begin
            h_next_s = 16'd0;
            v_next_s = 16'd0;
        end
    end

    assign hb_nx_s  = (h_next_s >= H);
    assign vb_nx_s  = (v_next_s >= V);
    assign hs_nx_s  = !(({1'b0, h_next_s} >= hs_start_s) && ({1'b0, h_next_s} < hs_end_s));
    assign vs_nx_s  = !(({1'b0, v_next_s} >= vs_start_s) && ({1'b0, v_next_s} < vs_end_s));
    assign vs_upd_s = started_r && ({1'b0, h_cnt_r} == vs_h_s);

    assign rd_head_s = lane_head_s[rd_ptr_r];
    assign rd_have_s = (lane_cnt_s[rd_ptr_r] != {(AW+1){1'b0}});
    assign rd_go_s   = ce_pix && de_r && rd_have_s;

    // Slot k of this cycle's write lands in lane (wr_ptr + k) mod LANES; each lane gets one slot
    always_comb begin
        logic [LW-1:0] li;
        li = {LW{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            wr_en_s[l]  = 1'b0;
            wr_pix_s[l] = {PW{1'b0}};
            rd_en_s[l]  = rd_go_s && (rd_ptr_r == LW'(l));
        end
        for (int k = 0; k < LANES; k++) begin
            li           = lane_add(wr_ptr_r, k);
            wr_en_s[li]  = (k < int'(wr_cnt));
            wr_pix_s[li] = wr_data[k*PW +: PW];
        end
    end

    // Total occupancy across the lanes
    always_comb begin
        queue_s = 24'd0;
        for (int l = 0; l < LANES; l++) begin
            queue_s = queue_s + 24'(lane_cnt_s[l]);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [PW-1:0] mem_r [DEPTH];
        logic [AW-1:0] wp_r, rp_r;
        logic [AW:0]   cnt_r;
        logic          wr_ok_s;

        // A read in the same cycle frees the slot, so a full lane still accepts
        assign wr_ok_s = wr_en_s[g] && ((cnt_r != (AW+1)'(DEPTH)) || rd_en_s[g]);

        // Pixel storage; contents are don't-care until counted
        always_ff @(posedge clk_sys) begin
            if (wr_ok_s) begin
                mem_r[wp_r] <= wr_pix_s[g];
            end
        end

        // Lane pointers and fill count
        always_ff @(posedge clk_sys or negedge vga_reset_n) begin
            if (!vga_reset_n) begin
                wp_r  <= {AW{1'b0}};
                rp_r  <= {AW{1'b0}};
                cnt_r <= {(AW+1){1'b0}};
            end else begin
                if (wr_ok_s) begin
                    wp_r <= wp_r + AW'(1);
                end
                if (rd_en_s[g]) begin
                    rp_r <= rp_r + AW'(1);
                end
                if (wr_ok_s && !rd_en_s[g]) begin
                    cnt_r <= cnt_r + (AW+1)'(1);
                end else if (!wr_ok_s && rd_en_s[g]) begin
                    cnt_r <= cnt_r - (AW+1)'(1);
                end
            end
        end

        assign lane_cnt_s[g]  = cnt_r;
        assign lane_head_s[g] = mem_r[rp_r];
    end

    // Write lane rotation runs every cycle regardless of ce_pix
    always_ff @(posedge clk_sys or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            wr_ptr_r <= {LW{1'b0}};
        end else begin
            wr_ptr_r <= lane_add(wr_ptr_r, int'(wr_cnt));
        end
    end

    // Raster counters, sync/blank outputs and the output pixel
    always_ff @(posedge clk_sys or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            started_r   <= 1'b0;
            h_cnt_r     <= 16'd0;
            v_cnt_r     <= 16'd0;
            hblank_r    <= 1'b1;
            vblank_r    <= 1'b1;
            de_r        <= 1'b0;
            hsync_r     <= 1'b1;
            vsync_r     <= 1'b1;
            frame_r     <= 32'd0;
            rgb_r       <= {PW{1'b0}};
            underflow_r <= 1'b0;
            rd_ptr_r    <= {LW{1'b0}};
        end else if (ce_pix) begin
            started_r <= 1'b1;
            h_cnt_r   <= h_next_s;
            v_cnt_r   <= v_next_s;
            hblank_r  <= hb_nx_s;
            vblank_r  <= vb_nx_s;
            de_r      <= !hb_nx_s && !vb_nx_s;
            hsync_r   <= hs_nx_s;
            if (vs_upd_s) begin
                vsync_r <= vs_nx_s;
            end
            if (wrap_s) begin
                frame_r <= frame_r + 32'd1;
            end
            if (de_r) begin
                rgb_r <= rd_have_s ? rd_head_s : FILL;
            end else begin
                rgb_r <= {PW{1'b0}};
            end
            if (wrap_s) begin
                underflow_r <= 1'b0;
            end else if (de_r && !rd_have_s) begin
                underflow_r <= 1'b1;
            end
            if (rd_go_s) begin
                rd_ptr_r <= lane_add(rd_ptr_r, 1);
            end
        end
    end

    assign queue     = queue_s;
    assign ready     = ((CAP_Q - queue_s) >= BURST_Q);
    assign hsync     = hsync_r;
    assign vsync     = vsync_r;
    assign hblank    = hblank_r;
    assign vblank    = vblank_r;
    assign de        = de_r;
    assign rgb       = rgb_r;
    assign frame     = frame_r;
    assign vcount    = v_cnt_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_vga_lanes.sv
// Bench for vga_lanes: directed scenarios plus randomized traffic against a queue/arithmetic reference.
module tb_vga_lanes;
    localparam int LANES = 3, DEPTH = 16, BURST = 8;
    localparam logic [23:0] FILL = 24'hFF0000;
    localparam int HV = 4, HFPV = 1, HSV = 1, HBPV = 2, VV = 2, VFPV = 1, VSV = 1, VBPV = 1;
    localparam int HTOT = HV + HFPV + HSV + HBPV;
    localparam int VTOT = VV + VFPV + VSV + VBPV;

    logic        clk_sys = 1'b0;
    logic        vga_reset_n = 1'b0;
    logic        ce_pix = 1'b0;
    logic [15:0] H = 16'(HV), V = 16'(VV);
    logic [7:0]  HFP = 8'(HFPV), HS = 8'(HSV), HBP = 8'(HBPV);
    logic [7:0]  VFP = 8'(VFPV), VS = 8'(VSV), VBP = 8'(VBPV);
    logic [1:0]  wr_cnt = 2'd0;
    logic [71:0] wr_data = 72'd0;
    logic        ready, hsync, vsync, hblank, vblank, de, underflow;
    logic [23:0] queue, rgb;
    logic [31:0] frame;
    logic [15:0] vcount;

    logic        ce1 = 1'b0;
    logic [0:0]  wr_cnt1 = 1'b0;
    logic [23:0] wr_data1 = 24'd0;
    logic        ready1, hsync1, vsync1, hblank1, vblank1, de1, underflow1;
    logic [23:0] queue1, rgb1;
    logic [31:0] frame1;
    logic [15:0] vcount1;
`ifdef VGA_LANES_INTERLACE_EN
    logic interlaced = 1'b0, field, field1;
`endif

    vga_lanes #(.LANES(LANES), .DEPTH(DEPTH), .PIX_W(8), .FILL(FILL), .BURST(BURST)) u_dut (
        .clk_sys(clk_sys), .vga_reset_n(vga_reset_n), .ce_pix(ce_pix),
        .H(H), .V(V), .HFP(HFP), .HS(HS), .HBP(HBP), .VFP(VFP), .VS(VS), .VBP(VBP),
        .wr_cnt(wr_cnt), .wr_data(wr_data),
`ifdef VGA_LANES_INTERLACE_EN
        .interlaced(interlaced), .field(field),
`endif
        .ready(ready), .queue(queue), .hsync(hsync), .vsync(vsync), .hblank(hblank),
        .vblank(vblank), .de(de), .rgb(rgb), .frame(frame), .vcount(vcount), .underflow(underflow));

    vga_lanes #(.LANES(1), .DEPTH(16), .PIX_W(8), .FILL(FILL), .BURST(1)) u_dut1 (
        .clk_sys(clk_sys), .vga_reset_n(vga_reset_n), .ce_pix(ce1),
        .H(H), .V(V), .HFP(HFP), .HS(HS), .HBP(HBP), .VFP(VFP), .VS(VS), .VBP(VBP),
        .wr_cnt(wr_cnt1), .wr_data(wr_data1),
`ifdef VGA_LANES_INTERLACE_EN
        .interlaced(1'b0), .field(field1),
`endif
        .ready(ready1), .queue(queue1), .hsync(hsync1), .vsync(vsync1), .hblank(hblank1),
        .vblank(vblank1), .de(de1), .rgb(rgb1), .frame(frame1), .vcount(vcount1), .underflow(underflow1));

    always #5 clk_sys = ~clk_sys;

    int tests = 0, fails = 0;

    // Reference: per-lane ring buffers, pointers, and raster position as a ce_pix count
    logic [23:0] mbuf [LANES][DEPTH];
    int          mhd [LANES];
    int          msz [LANES];
    int          m_wr, m_rd, m_p;
    bit          m_started, m_uf;
    logic [23:0] m_rgb;

    function automatic int h_of(input int p);
        return p % HTOT;
    endfunction
    function automatic int v_of(input int p);
        return ((p + HTOT - (HV + HFPV + 1)) / HTOT) % VTOT;
    endfunction
    function automatic int f_of(input int p);
        return (p + HTOT - (HV + HFPV + 1)) / (HTOT * VTOT);
    endfunction
    function automatic bit de_of(input int p);
        return (h_of(p) < HV) && (v_of(p) < VV);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            mhd[l] = 0;
            msz[l] = 0;
        end
        m_wr = 0; m_rd = 0; m_p = 0;
        m_started = 1'b0; m_uf = 1'b0; m_rgb = 24'd0;
    endtask

    task automatic check_all();
        int q, h, v;
        q = 0;
        for (int l = 0; l < LANES; l++) q += msz[l];
        chk("queue", 64'(queue), 64'(q));
        chk("ready", 64'(ready), 64'((LANES * DEPTH - q) >= BURST));
        chk("rgb", 64'(rgb), 64'(m_rgb));
        chk("underflow", 64'(underflow), 64'(m_uf));
        if (!m_started) begin
            chk("rst_hsync", 64'(hsync), 64'd1);
            chk("rst_vsync", 64'(vsync), 64'd1);
            chk("rst_hblank", 64'(hblank), 64'd1);
            chk("rst_vblank", 64'(vblank), 64'd1);
            chk("rst_de", 64'(de), 64'd0);
            chk("rst_frame", 64'(frame), 64'd0);
        end else begin
            h = h_of(m_p);
            v = v_of(m_p);
            chk("hsync", 64'(hsync), 64'(!(h >= HV + HFPV && h < HV + HFPV + HSV)));
            chk("vsync", 64'(vsync), 64'(!(v >= VV + VFPV && v < VV + VFPV + VSV)));
            chk("hblank", 64'(hblank), 64'(h >= HV));
            chk("vblank", 64'(vblank), 64'(v >= VV));
            chk("de", 64'(de), 64'(de_of(m_p)));
            chk("vcount", 64'(vcount), 64'(v));
            chk("frame", 64'(frame), 64'(f_of(m_p)));
        end
    endtask

    task automatic step(input bit ce, input int cnt, input logic [71:0] data);
        bit uf_evt;
        int ln;
        ce_pix  = ce;
        wr_cnt  = 2'(cnt);
        wr_data = data;
        @(posedge clk_sys);
        #1;
        uf_evt = 1'b0;
        if (ce) begin
            if (!m_started) begin
                m_started = 1'b1;
                m_p = 0;
                m_rgb = 24'd0;
            end else begin
                if (de_of(m_p)) begin
                    if (msz[m_rd] > 0) begin
                        m_rgb = mbuf[m_rd][mhd[m_rd]];
                        mhd[m_rd] = (mhd[m_rd] + 1) % DEPTH;
                        msz[m_rd]--;
                        m_rd = (m_rd + 1) % LANES;
                    end else begin
                        m_rgb = FILL;
                        uf_evt = 1'b1;
                    end
                end else begin
                    m_rgb = 24'd0;
                end
                if (f_of(m_p + 1) != f_of(m_p)) m_uf = 1'b0;
                if (uf_evt) m_uf = 1'b1;
                m_p++;
            end
        end
        for (int k = 0; k < cnt; k++) begin
            ln = (m_wr + k) % LANES;
            if (msz[ln] < DEPTH) begin
                mbuf[ln][(mhd[ln] + msz[ln]) % DEPTH] = data[k*24 +: 24];
                msz[ln]++;
            end
        end
        m_wr = (m_wr + cnt) % LANES;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        vga_reset_n = 1'b0;
        ce_pix = 1'b0; wr_cnt = 2'd0;
        #1;
        model_reset();
        check_all();
        chk("rst_queue1", 64'(queue1), 64'd0);
        @(posedge clk_sys);
        #1;
        check_all();
        @(negedge clk_sys);
        vga_reset_n = 1'b1;
    endtask

    initial begin
        logic [23:0] cap [$];
        logic [23:0] exp4 [4];
        logic [71:0] d;
        int          f0, nrd;
        bit          uf_seen;

        exp4 = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        check_all();
        @(negedge clk_sys);
        vga_reset_n = 1'b1;

        // Two 2-pixel writes rotate over lanes 0,1,2,0 and read back in order
        step(1'b0, 2, {24'd0, exp4[1], exp4[0]});
        step(1'b0, 2, {24'd0, exp4[3], exp4[2]});
        chk("q4", 64'(queue), 64'd4);
        for (int i = 0; i < 60 && cap.size() < 4; i++) begin
            step(1'b1, 0, 72'd0);
            if (rgb !== 24'd0 && rgb !== FILL) cap.push_back(rgb);
        end
        chk("order_len", 64'(cap.size()), 64'd4);
        for (int i = 0; i < cap.size() && i < 4; i++) chk("order", 64'(cap[i]), 64'(exp4[i]));

        // Empty lanes during de give FILL and a sticky underflow cleared at the vertical wrap
        uf_seen = 1'b0;
        for (int i = 0; i < 20 && !uf_seen; i++) begin
            step(1'b1, 0, 72'd0);
            if (underflow === 1'b1 && rgb === FILL) uf_seen = 1'b1;
        end
        chk("uf_seen", 64'(uf_seen), 64'd1);
        f0 = int'(frame);
        for (int i = 0; i < 2 * HTOT * VTOT && int'(frame) == f0; i++) step(1'b1, 0, 72'd0);
        chk("frame_inc", 64'(frame), 64'(f0 + 1));
        chk("uf_clear", 64'(underflow), 64'd0);

        // Randomized traffic with gated ce_pix
        for (int i = 0; i < 1500; i++) begin
            d[31:0]  = $urandom;
            d[63:32] = $urandom;
            d[71:64] = 8'($urandom);
            step($urandom_range(0, 3) != 0, ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3)), d);
        end

        // Single-lane depth-16 FIFO: overflow drops, ready deasserts, only first 16 pixels emerge
        for (int i = 0; i < 20; i++) begin
            wr_cnt1  = 1'b1;
            wr_data1 = 24'(i + 1);
            step(1'b0, 0, 72'd0);
            chk("q1_fill", 64'(queue1), 64'((i + 1 < 16) ? i + 1 : 16));
            chk("ready1", 64'(ready1), 64'(i + 1 < 16));
        end
        wr_cnt1 = 1'b0;
        cap.delete();
        ce1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 0, 72'd0);
            if (rgb1 !== 24'd0 && rgb1 !== FILL) cap.push_back(rgb1);
        end
        ce1 = 1'b0;
        chk("drop_len", 64'(cap.size()), 64'd16);
        nrd = (cap.size() < 16) ? cap.size() : 16;
        for (int i = 0; i < nrd; i++) chk("drop_seq", 64'(cap[i]), 64'(i + 1));

        // Mid-line reset with ten pixels buffered
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 0, 72'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 3, {24'hC0FFEE, 24'h00BEEF, 24'h123456});
        step(1'b0, 1, {48'd0, 24'h0ABCDE});
        chk("q10", 64'(queue), 64'd10);
        do_reset();
        step(1'b1, 0, 72'd0);
        chk("restart_vc", 64'(vcount), 64'd0);

`ifdef VGA_LANES_INTERLACE_EN
        begin
            int flist [$];
            int vlist [$];
            do_reset();
            interlaced = 1'b1;
            flist.push_back(int'(field));
            for (int i = 0; i < 3 * HTOT * VTOT; i++) begin
                ce_pix = 1'b1;
                @(posedge clk_sys);
                #1;
                if (int'(field) != flist[flist.size() - 1]) flist.push_back(int'(field));
                if (field === 1'b1 && flist.size() == 2 &&
                    (vlist.size() == 0 || vlist[vlist.size() - 1] != int'(vcount)))
                    vlist.push_back(int'(vcount));
            end
            ce_pix = 1'b0;
            chk("field_n", 64'(flist.size() >= 3), 64'd1);
            for (int i = 0; i < 3 && i < flist.size(); i++) chk("field_seq", 64'(flist[i]), 64'(i % 2));
            chk("f1_vlen", 64'(vlist.size()), 64'd2);
            for (int i = 0; i < 2 && i < vlist.size(); i++) chk("f1_vcount", 64'(vlist[i]), 64'(2 * i + 1));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_lanes.md
VGA_LANES -- requirements
Module: vga_lanes

Interface
REQ-001 SHALL have parameter LANES, default 3, meaning number of parallel pixel lanes (1..4).
REQ-002 SHALL have parameter DEPTH, default 512, meaning per-lane FIFO depth in pixels (power of two, >=16).
REQ-003 SHALL have parameter PIX_W, default 8, meaning bits per colour channel.
REQ-004 SHALL have parameter FILL, default {PIX_W{1}},{PIX_W{0}},{PIX_W{0}} (red), meaning the underflow pixel value.
REQ-005 SHALL have parameter BURST, default 342, meaning the minimum free space required to assert ready.
REQ-006 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-007 SHALL have port vga_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port ce_pix, input, 1 bit: pixel-clock enable.
REQ-009 SHALL have ports H and V, input, 16 bits each: visible width and height.
REQ-010 SHALL have ports HFP, HS, HBP, VFP, VS and VBP, input, 8 bits each: porch and sync widths.
REQ-011 SHALL have port wr_cnt, input, clog2(LANES+1) bits: number of pixels written this cycle (0..LANES).
REQ-012 SHALL have port wr_data, input, LANES*3*PIX_W bits: packed pixels, slot 0 in the LSBs, {R,G,B} per slot.
REQ-013 SHALL have port ready, output, 1 bit: total free space >= BURST.
REQ-014 SHALL have port queue, output, 24 bits: total pixels stored across all lanes.
REQ-015 SHALL have ports hsync and vsync, output, 1 bit each, active-low; hblank, vblank and de, output, 1 bit each.
REQ-016 SHALL have port rgb, output, 3*PIX_W bits: the output pixel.
REQ-017 SHALL have port frame, output, 32 bits: count of completed frames.
REQ-018 SHALL have port vcount, output, 16 bits: current line.
REQ-019 SHALL have port underflow, output, 1 bit: sticky flag meaning an underflow occurred this frame.

Function
REQ-020 SHALL fit wr_cnt slots k=0..wr_cnt-1 into lane (wr_ptr+k) mod LANES, then advance wr_ptr by wr_cnt mod LANES in the same cycle.
REQ-021 SHALL silently drop writes to a full lane, and the drop SHALL NOT advance that slot's lane pointer contribution (wr_ptr still advances by wr_cnt).
REQ-022 SHALL use show-ahead FIFOs, with one pixel read per de cycle (on ce_pix) from lane rd_ptr, after which rd_ptr advances mod LANES.
REQ-023 SHALL output FILL when the lane at rd_ptr is empty during de, set underflow, and leave rd_ptr unadvanced.
REQ-024 SHALL register rgb one ce_pix after counter state, and drive rgb = 0 when de is low.
REQ-025 SHALL count h_cnt 0..Htot-1, where Htot = H+HFP+HS+HBP, and advance v_cnt 0..Vtot-1 at h_cnt==H+HFP.
REQ-026 SHALL set hblank when h_cnt>=H, vblank when v_cnt>=V, and de = !hblank & !vblank.
REQ-027 SHALL assert hsync low for h_cnt in [H+HFP, H+HFP+HS).
REQ-028 SHALL update vsync at h_cnt==H+HFP, low for v_cnt in [V+VFP, V+VFP+VS).
REQ-029 SHALL increment frame when v_cnt wraps to 0, wrapping at 2^32.
REQ-030 SHALL clear underflow at that same wrap.
REQ-031 SHALL compute queue and ready combinationally from the lane fill counts; queue SHALL be exact in the cycle after any write or read.
REQ-032 SHALL give the read priority on a simultaneous read and write to the same lane, with the count changing by net zero.
REQ-033 SHALL leave counters and pointers unchanged when ce_pix is low; writes are independent of ce_pix.

Reset
REQ-034 SHALL, while vga_reset_n is low, clear h_cnt, v_cnt, wr_ptr, rd_ptr, frame, underflow, rgb and every FIFO.
REQ-035 SHALL, while vga_reset_n is low, drive hsync=1, vsync=1, hblank=1, vblank=1, de=0, queue=0 and ready=1.
REQ-036 SHALL, on reset assertion mid-frame, discard all buffered pixels immediately and start at h_cnt=0, v_cnt=0 on the first ce_pix after release.

Configuration
REQ-037 SHALL, when VGA_LANES_INTERLACE_EN is defined, add input interlaced (1 bit) and output field (1 bit).
REQ-038 SHALL, with VGA_LANES_INTERLACE_EN defined and interlaced=1, toggle field at each v_cnt wrap and count v_cnt by 2 starting at field.
REQ-039 SHALL, with VGA_LANES_INTERLACE_EN defined, move vsync edges in field 1 to h_cnt==Htot/2.
REQ-040 SHALL, without VGA_LANES_INTERLACE_EN, omit both the interlaced and field ports and behave progressive-only.

Verification
REQ-041 SHALL cover: LANES=3, wr_cnt=2 twice with pixels A,B then C,D -> lanes 0,1,2,0 hold A,B,C,D; queue=4; rgb order A,B,C,D.
REQ-042 SHALL cover: H=4, HFP=1, HS=1, HBP=2, V=2, VFP=1, VS=1, VBP=1 -> hsync low at h_cnt 5; vsync low on line 3; frame increments every 40 ce_pix.
REQ-043 SHALL cover: empty FIFOs during de -> rgb=FILL, underflow=1; underflow=0 after the v_cnt wrap.
REQ-044 SHALL cover: DEPTH=16, LANES=1, 20 writes without reads -> queue=16, extra pixels dropped, ready=0 with BURST=1.
REQ-045 SHALL cover: vga_reset_n pulsed low mid-line with queue=10 -> queue=0, all outputs at reset values asynchronously.
REQ-046 SHALL cover: VGA_LANES_INTERLACE_EN defined, interlaced=1 -> field alternates 0,1; field-1 vcount sequence 1,3,...
